// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: load/store unit between EXU and WBU.
// One memory transaction at a time over a req/gnt/rvalid bus.
module ysyx_25020047_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] inst_type,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] memdata,
  output logic        out_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [63:0] OP_LW  = 64'd1 << 5;
  localparam logic [63:0] OP_LBU = 64'd1 << 6;
  localparam logic [63:0] OP_LB  = 64'd1 << 37;
  localparam logic [63:0] OP_LH  = 64'd1 << 38;
  localparam logic [63:0] OP_LHU = 64'd1 << 39;
  localparam logic [63:0] OP_SW  = 64'd1 << 40;
  localparam logic [63:0] OP_SH  = 64'd1 << 41;
  localparam logic [63:0] OP_SB  = 64'd1 << 42;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [63:0] itype_q;
  logic [1:0]  off_q;

  logic is_lw, is_lbu, is_lb, is_lh, is_lhu;
  logic is_sw, is_sh, is_sb;
  logic is_ld, is_st, mis;
  logic [3:0]  wmask_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val;

  // Decode the incoming opcode; non one-hot values fall out as non-memory.
  always_comb begin
    is_lw  = inst_type == OP_LW;
    is_lbu = inst_type == OP_LBU;
    is_lb  = inst_type == OP_LB;
    is_lh  = inst_type == OP_LH;
    is_lhu = inst_type == OP_LHU;
    is_sw  = inst_type == OP_SW;
    is_sh  = inst_type == OP_SH;
    is_sb  = inst_type == OP_SB;
    is_ld  = is_lw | is_lbu | is_lb | is_lh | is_lhu;
    is_st  = is_sw | is_sh | is_sb;
    mis    = ((is_lw | is_sw) & (addr[1:0] != 2'b00))
           | ((is_lh | is_lhu | is_sh) & addr[0]);
  end

  // Byte enables and lane-replicated write data for stores.
  always_comb begin
    wmask_d = 4'b0000;
    wdata_d = 32'h0;
    if (is_sb) begin
      wmask_d = 4'b0001 << addr[1:0];
      wdata_d = {4{st_data[7:0]}};
    end else if (is_sh) begin
      wmask_d = addr[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{st_data[15:0]}};
    end else if (is_sw) begin
      wmask_d = 4'b1111;
      wdata_d = st_data;
    end
  end

  // Align and extend the returned word for the latched load kind.
  always_comb begin
    byte_v = mem_rdata[8*off_q +: 8];
    half_v = mem_rdata[16*off_q[1] +: 16];
    ld_val = 32'h0;
    if (itype_q == OP_LB)
      ld_val = {{24{byte_v[7]}}, byte_v};
    else if (itype_q == OP_LBU)
      ld_val = {24'h0, byte_v};
    else if (itype_q == OP_LH)
      ld_val = {{16{half_v[15]}}, half_v};
    else if (itype_q == OP_LHU)
      ld_val = {16'h0, half_v};
    else if (itype_q == OP_LW)
      ld_val = mem_rdata;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if ((is_ld | is_st) & ~mis) state_nxt = REQ;
          else                        state_nxt = RESP;
        end
      end
      REQ: begin
        if (mem_gnt & mem_rvalid) state_nxt = RESP;
        else if (mem_gnt)         state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_nxt = RESP;
      end
      RESP: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE) & ~rst;
    mem_req   = state == REQ;
    out_valid = state == RESP;
  end

  // Latch the request at accept and capture the response data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      itype_q   <= 64'h0;
      off_q     <= 2'b00;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wmask <= 4'b0000;
      memdata   <= 32'h0;
      out_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            itype_q   <= inst_type;
            off_q     <= addr[1:0];
            mem_addr  <= {addr[31:2], 2'b00};
            mem_we    <= is_st & ~mis;
            mem_wmask <= mis ? 4'b0000 : wmask_d;
            mem_wdata <= mis ? 32'h0 : wdata_d;
            memdata   <= 32'h0;
            out_err   <= mis;
          end
        end
        REQ: begin
          if (mem_gnt & mem_rvalid) memdata <= ld_val;
        end
        WAIT: begin
          if (mem_rvalid) memdata <= ld_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// tb_ysyx_25020047_lsu: directed bench for the load/store unit
// with an arithmetic reference model and a per-cycle checker.
module tb_ysyx_25020047_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] inst_type = 64'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] memdata;
  logic        out_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  ysyx_25020047_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .addr(addr), .st_data(st_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .memdata(memdata), .out_err(out_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] md;
    logic        err;
    logic        bus;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] baddr;
    int          lat;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs = 0;
  int cur_g = 0;
  int cur_r = 1;
  bit busy = 0;
  bit seen = 0;
  exp_t q[$];

  logic [31:0] last_md;
  logic        last_err;
  logic [31:0] last_addr;
  logic [3:0]  last_mask;
  logic [31:0] last_wdata;
  logic        last_we;
  int          last_lat;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [63:0] it,
                                 input logic [31:0] a,
                                 input logic [31:0] sd,
                                 input logic [31:0] rd,
                                 input int g, input int r);
    exp_t e;
    logic [31:0] b, h;
    int o4, o2;
    o4 = int'(a % 4);
    o2 = int'((a / 2) % 2);
    b = (rd >> (8 * o4)) & 32'hFF;
    h = (rd >> (16 * o2)) & 32'hFFFF;
    e.md = 0; e.err = 0; e.bus = 1; e.we = 0;
    e.mask = 0; e.wdata = 0;
    e.baddr = a - (a % 4);
    if (it == 64'd1 << 5) begin
      e.err = o4 != 0; e.md = rd;
    end else if (it == 64'd1 << 6) begin
      e.md = b;
    end else if (it == 64'd1 << 37) begin
      e.md = (b >= 128) ? b - 32'd256 : b;
    end else if (it == 64'd1 << 38) begin
      e.err = (a % 2) != 0;
      e.md = (h >= 32768) ? h - 32'd65536 : h;
    end else if (it == 64'd1 << 39) begin
      e.err = (a % 2) != 0; e.md = h;
    end else if (it == 64'd1 << 40) begin
      e.err = o4 != 0; e.we = 1;
      e.mask = 4'd15; e.wdata = sd;
    end else if (it == 64'd1 << 41) begin
      e.err = (a % 2) != 0; e.we = 1;
      e.mask = 4'(3 << (2 * o2));
      e.wdata = (sd & 32'hFFFF) * 32'h0001_0001;
    end else if (it == 64'd1 << 42) begin
      e.we = 1;
      e.mask = 4'(1 << o4);
      e.wdata = (sd & 32'hFF) * 32'h0101_0101;
    end else begin
      e.bus = 0;
    end
    if (e.err) begin
      e.bus = 0; e.md = 0;
    end
    if (e.we) e.md = 0;
    e.lat = e.bus ? 2 + g + r : 1;
    return e;
  endfunction

  // Per-cycle checker against the model queue.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      busy = 0;
      seen = 0;
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!busy));
      if (mem_req) begin
        chk("req_allowed", 32'(q.size() > 0 && q[0].bus), 1);
        if (q.size() > 0) begin
          chk("mem_addr", mem_addr, q[0].baddr);
          chk("mem_we", 32'(mem_we), 32'(q[0].we));
          chk("mem_wmask", 32'(mem_wmask), 32'(q[0].mask));
          chk("mem_wdata", mem_wdata, q[0].wdata);
          last_addr = mem_addr;
          last_mask = mem_wmask;
          last_wdata = mem_wdata;
          last_we = mem_we;
        end
      end
      if (out_valid) begin
        chk("valid_allowed", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          chk("memdata", memdata, q[0].md);
          chk("out_err", 32'(out_err), 32'(q[0].err));
          if (!seen) begin
            seen = 1;
            last_lat = cyc - acc_cyc;
            chk("latency", last_lat, q[0].lat);
          end
          if (out_ready) begin
            last_md = memdata;
            last_err = out_err;
            hs++;
            void'(q.pop_front());
            busy = 0;
            seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(inst_type, addr, st_data, mem_rdata,
                          cur_g, cur_r));
        acc_cyc = cyc;
        busy = 1;
      end
    end
  end

  task automatic do_op(input logic [63:0] it, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd,
                       input int g, input int r, input int o);
    exp_t e;
    int target;
    e = model(it, a, sd, rd, g, r);
    cur_g = g;
    cur_r = r;
    mem_rdata = rd;
    @(posedge clk); #1;
    inst_type = it; addr = a; st_data = sd; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    target = hs + 1;
    if (e.bus) begin
      repeat (g) begin @(posedge clk); #1; end
      mem_gnt = 1;
      if (r == 0) mem_rvalid = 1;
      chk("req_at_gnt", 32'(mem_req), 1);
      @(posedge clk); #1;
      mem_gnt = 0;
      mem_rvalid = 0;
      if (r > 0) begin
        chk("req_dropped", 32'(mem_req), 0);
        repeat (r - 1) begin @(posedge clk); #1; end
        mem_rvalid = 1;
        @(posedge clk); #1;
        mem_rvalid = 0;
      end
    end
    repeat (o) begin @(posedge clk); #1; end
    out_ready = 1;
    for (int k = 0; k < 60; k++) begin
      if (hs == target) break;
      @(posedge clk); #1;
    end
    out_ready = 0;
    chk("handshakes", hs, target);
  endtask

  initial begin
    #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_memdata", memdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", 32'(mem_wmask), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    do_op(64'd1 << 5, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0, 1, 0);
    chk("lw_lit", last_md, 32'hDEAD_BEEF);
    chk("lw_addr_lit", last_addr, 32'h8000_0004);
    chk("lw_mask_lit", 32'(last_mask), 0);
    chk("lw_lat_lit", last_lat, 3);

    do_op(64'd1 << 37, 32'h8000_0003, 0, 32'h8012_3456, 0, 1, 0);
    chk("lb_lit", last_md, 32'hFFFF_FF80);
    do_op(64'd1 << 6, 32'h8000_0003, 0, 32'h8012_3456, 0, 1, 0);
    chk("lbu_lit", last_md, 32'h0000_0080);
    do_op(64'd1 << 38, 32'h8000_0002, 0, 32'h8012_3456, 0, 1, 0);
    chk("lh_lit", last_md, 32'hFFFF_8012);
    do_op(64'd1 << 39, 32'h8000_0002, 0, 32'h8012_3456, 1, 0, 1);

    do_op(64'd1 << 42, 32'h8000_0001, 32'h0000_00AB, 32'h5555_5555,
          0, 1, 0);
    chk("sb_we_lit", 32'(last_we), 1);
    chk("sb_mask_lit", 32'(last_mask), 32'h2);
    chk("sb_wdata_lit", last_wdata, 32'hABAB_ABAB);
    chk("sb_md_lit", last_md, 0);
    do_op(64'd1 << 41, 32'h8000_0002, 32'h1234_CDEF, 32'h5555_5555,
          0, 1, 0);
    chk("sh_mask_lit", 32'(last_mask), 32'hC);
    do_op(64'd1 << 40, 32'h8000_0008, 32'h1234_5678, 32'h0, 0, 0, 0);
    chk("sw_lat_lit", last_lat, 2);

    do_op(64'd1 << 5, 32'h8000_0002, 0, 32'h1111_1111, 0, 1, 0);
    chk("mis_err_lit", 32'(last_err), 1);
    chk("mis_lat_lit", last_lat, 1);
    do_op(64'h1, 32'h0000_0010, 0, 32'h1111_1111, 0, 1, 0);
    chk("addi_err_lit", 32'(last_err), 0);
    chk("addi_md_lit", last_md, 0);
    do_op(64'd1 << 41, 32'h8000_0003, 32'hFFFF, 32'h0, 0, 1, 0);

    do_op(64'd1 << 5, 32'h8000_0010, 0, 32'hCAFE_F00D, 3, 3, 4);
    chk("stall_md_lit", last_md, 32'hCAFE_F00D);
    chk("stall_lat_lit", last_lat, 8);

    cur_g = 0;
    cur_r = 5;
    mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    inst_type = 64'd1 << 5; addr = 32'h8000_0008; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("arst_mem_req", 32'(mem_req), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 0;
    mem_rvalid = 1;
    @(posedge clk); #1;
    mem_rvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_out_valid", 32'(out_valid), 0);
    do_op(64'd1 << 5, 32'h8000_000C, 0, 32'h0BAD_F00D, 0, 1, 0);
    chk("post_rst_lit", last_md, 32'h0BAD_F00D);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
